// File: rtl/note_sequencer.sv
// Steps through a loadable (period, duration) pattern, driving the tone divider's
// count_to and a note gate, with a one-tick articulation gap between steps.
//
// state | meaning
// IDLE  | waiting for start; pattern writes accepted
// LOAD  | fetch entry[step_idx]; a zero duration marks end of pattern
// PLAY  | note sounds for dur ticks
// GAP   | one tick of silence before the next step
module note_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [7:0]               wr_note,
  input  logic [DUR_W-1:0]         wr_dur,
  output logic [7:0]               count_to,
  output logic                     gate,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done
);
  localparam int IW = $clog2(STEPS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int EW = 8 + DUR_W;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        count_to_q, count_to_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IW-1:0]     step_q, step_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [EW-1:0]     mem_q [STEPS];
  logic              mem_we;
  logic [7:0]        rd_note;
  logic [DUR_W-1:0]  rd_dur;
  logic              last_tick;

  assign rd_note   = mem_q[step_q][EW-1:DUR_W];
  assign rd_dur    = mem_q[step_q][DUR_W-1:0];
  assign last_tick = (tick_q == TW'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    count_to_d = count_to_q;
    gate_d     = gate_q;
    done_d     = 1'b0;
    step_d     = step_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        mem_we = wr_en;
        if (start) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end
      LOAD: begin
        if (rd_dur == '0) begin
          // a marker at entry 0 ends playback even with loop set, so it cannot spin
          if (loop && step_q != '0) begin
            step_d = '0;
          end else begin
            state_d    = IDLE;
            done_d     = 1'b1;
            step_d     = '0;
            count_to_d = 8'h00;
            gate_d     = 1'b0;
          end
        end else begin
          state_d    = PLAY;
          count_to_d = rd_note;
          gate_d     = (rd_note != 8'h00);
          dur_d      = rd_dur;
          tick_d     = '0;
        end
      end
      PLAY: begin
        tick_d = last_tick ? '0 : tick_q + TW'(1);
        if (last_tick) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            state_d = GAP;
            gate_d  = 1'b0;
          end
        end
      end
      GAP: begin
        tick_d = last_tick ? '0 : tick_q + TW'(1);
        if (last_tick) begin
          if (step_q == IW'(STEPS - 1)) begin
            // running off the last entry behaves like reading a marker
            step_d = '0;
            if (loop) begin
              state_d = LOAD;
            end else begin
              state_d    = IDLE;
              done_d     = 1'b1;
              count_to_d = 8'h00;
            end
          end else begin
            step_d  = step_q + IW'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d    = IDLE;
      count_to_d = 8'h00;
      gate_d     = 1'b0;
      done_d     = 1'b0;
      step_d     = '0;
      tick_d     = '0;
      dur_d      = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_to_q <= 8'h00;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_to_q <= count_to_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
    end
  end

  // pattern storage survives reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= {wr_note, wr_dur};
  end

  assign count_to = count_to_q;
  assign gate     = gate_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table, hand-written corner sequences and
// randomized patterns checked against a per-cycle trace built from the pattern.
module tb_note_sequencer;
  localparam int TD    = 4;
  localparam int STEPS = 16;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop, wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_note;
  logic [3:0] wr_dur;
  logic [7:0] count_to;
  logic       gate, busy, done;
  logic [3:0] step_idx;

  note_sequencer #(.STEPS(STEPS), .TICK_DIV(TD), .DUR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .count_to(count_to), .gate(gate), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] pat_note [STEPS];
  logic [3:0] pat_dur  [STEPS];

  typedef struct {
    logic [7:0] ct;
    logic       gate;
    logic       busy;
    logic       done;
    logic [3:0] step;
    bit         chk_ct;
    bit         chk_step;
    bit         drv_loop;
  } smp_t;
  smp_t expq[$];

  typedef struct {
    bit         start;
    bit         stop;
    logic [7:0] ct;
    logic       gate;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } vec_t;

  task automatic check(input string name, input logic [7:0] ect, input logic eg, input logic eb,
                       input logic ed, input logic [3:0] est, input bit cc, input bit cs);
    n_assert++;
    if ((cc && count_to !== ect) || gate !== eg || busy !== eb || done !== ed ||
        (cs && step_idx !== est)) begin
      n_fail++;
      $display("FAIL %s t=%0t: got count_to=%02h gate=%b busy=%b done=%b step=%0d, expected count_to=%02h gate=%b busy=%b done=%b step=%0d",
               name, $time, count_to, gate, busy, done, step_idx, ect, eg, eb, ed, est);
    end
  endtask

  function automatic void push(input logic [7:0] ct, input logic g, input logic b, input logic d,
                               input logic [3:0] st, input bit cc, input bit cs, input bit lp);
    smp_t s;
    s.ct = ct; s.gate = g; s.busy = b; s.done = d; s.step = st;
    s.chk_ct = cc; s.chk_step = cs; s.drv_loop = lp;
    expq.push_back(s);
  endfunction

  // Expected trace, one entry per clock edge after start is presented.
  // nrest = how many pattern ends should restart playback (loop held high until used).
  task automatic build_model(input int nrest);
    int idx = 0;
    int left = nrest;
    logic [7:0] ct = 8'h00;
    bit fin = 0;
    expq.delete();
    push(ct, 1'b0, 1'b1, 1'b0, 4'd0, 1, 1, left > 0);
    while (!fin) begin
      if (pat_dur[idx] == 4'd0) begin
        if (left > 0 && idx != 0) begin
          push(ct, 1'b0, 1'b1, 1'b0, 4'd0, 1, 1, 1);
          left--;
          idx = 0;
        end else begin
          push(8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 0, 0, left > 0);
          fin = 1;
        end
      end else begin
        ct = pat_note[idx];
        repeat (int'(pat_dur[idx]) * TD) push(ct, ct != 8'h00, 1'b1, 1'b0, 4'(idx), 1, 1, left > 0);
        repeat (TD) push(ct, 1'b0, 1'b1, 1'b0, 4'(idx), 1, 1, left > 0);
        if (idx == STEPS - 1) begin
          if (left > 0) begin
            push(ct, 1'b0, 1'b1, 1'b0, 4'd0, 1, 1, 1);
            left--;
            idx = 0;
          end else begin
            push(8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 0, 0, 0);
            fin = 1;
          end
        end else begin
          idx++;
          push(ct, 1'b0, 1'b1, 1'b0, 4'(idx), 1, 1, left > 0);
        end
      end
    end
    push(8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0);
    push(8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0, 0);
  endtask

  task automatic run_check(input string name, input int nrest, input int wr_cyc,
                           input logic [3:0] wa, input logic [7:0] wn, input logic [3:0] wd);
    build_model(nrest);
    for (int j = 0; j < expq.size(); j++) begin
      start   = (j == 0);
      loop    = expq[j].drv_loop;
      wr_en   = (j == wr_cyc);
      wr_addr = wa; wr_note = wn; wr_dur = wd;
      @(posedge clk); #1;
      check(name, expq[j].ct, expq[j].gate, expq[j].busy, expq[j].done, expq[j].step,
            expq[j].chk_ct, expq[j].chk_step);
    end
    start = 1'b0; loop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [7:0] n, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < STEPS; i++) write_entry(4'(i), pat_note[i], pat_dur[i]);
  endtask

  task automatic set_pattern1();
    for (int i = 0; i < STEPS; i++) begin
      pat_note[i] = 8'h00;
      pat_dur[i]  = 4'd0;
    end
    pat_note[0] = 8'h40; pat_dur[0] = 4'd2;
    pat_note[1] = 8'h00; pat_dur[1] = 4'd1;
    pat_note[2] = 8'h80; pat_dur[2] = 4'd1;
    pat_note[3] = 8'h5A; pat_dur[3] = 4'd0;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{1, 1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1] = '{0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[2] = '{1, 0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vt[3] = '{0, 0, 8'h40, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[4] = '{0, 0, 8'h40, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[5] = '{0, 0, 8'h40, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[6] = '{0, 1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[7] = '{0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[8] = '{0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_note = 8'h00; wr_dur = 4'd0;
    #12;
    check("reset", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1, 1);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    set_pattern1();
    load_pattern();

    // stop three cycles into e0, and start+stop together in IDLE
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start;
      stop  = vt[i].stop;
      @(posedge clk); #1;
      check($sformatf("stop_vec%0d", i), vt[i].ct, vt[i].gate, vt[i].busy, vt[i].done, vt[i].step, 1, 1);
    end
    start = 1'b0; stop = 1'b0;

    run_check("basic_play", 0, -1, 4'd0, 8'h00, 4'd0);
    run_check("loop_once", 1, -1, 4'd0, 8'h00, 4'd0);
    run_check("wr_during_play", 0, 3, 4'd0, 8'h11, 4'd1);
    run_check("replay_after_wr", 0, -1, 4'd0, 8'h00, 4'd0);

    for (int i = 0; i < STEPS; i++) begin
      pat_note[i] = 8'($urandom_range(0, 255));
      pat_dur[i]  = 4'd1;
    end
    load_pattern();
    run_check("wrap_16", 0, -1, 4'd0, 8'h00, 4'd0);

    pat_dur[0] = 4'd0;
    write_entry(4'd0, pat_note[0], 4'd0);
    run_check("marker_e0_loop", 1, -1, 4'd0, 8'h00, 4'd0);

    // async reset in the middle of e0
    set_pattern1();
    load_pattern();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_play", 8'h40, 1'b1, 1'b1, 1'b0, 4'd0, 1, 1);
    #2 rst = 1'b1;
    #1 check("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_check("replay_after_rst", 0, -1, 4'd0, 8'h00, 4'd0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < STEPS; i++) begin
        pat_note[i] = 8'($urandom_range(0, 255));
        pat_dur[i]  = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      load_pattern();
      run_check($sformatf("random%0d", r), int'($urandom_range(0, 1)), -1, 4'd0, 8'h00, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
